memory_r2_tank_ctrl: RTL and testbench
======================================

# memory_r2_tank_ctrl

Sequencer and two-port arbiter for one EDSAC mercury delay-line tank, the r2 upper tank. The tank circulates 32 short words, or 16 long words, of 18 digit periods each. The block keeps track of which word is at the tank output in every digit period. It accepts read and write requests from two requesters, port A (order unit fetch) and port B (arithmetic unit operand). For each granted request it waits for the addressed word to come round, then drives the tank's clear/in/out gates for exactly that word's digit window.

## Interface
Parameters:
- DIGITS, default 18: digit periods per short word (17 data digits plus 1 gap).
- WORDS, default 32: short words per circulation.

Ports:
- r2_clk, in, 1: digit clock, one edge per digit period.
- r2_rst, in, 1: reset, asynchronous, active-high.
- req_a, in, 1: port A request. Held high until gnt_a.
- req_a_wr, in, 1: port A direction. 1 = write, 0 = read.
- req_a_long, in, 1: port A long-word (36-digit) access.
- req_a_addr, in, 5: port A short-word address.
- req_b, in, 1: port B request. Held high until gnt_b.
- req_b_wr, in, 1: port B direction. 1 = write, 0 = read.
- req_b_long, in, 1: port B long-word (36-digit) access.
- req_b_addr, in, 5: port B short-word address.
- gnt_a, out, 1: one-cycle pulse granting port A.
- gnt_b, out, 1: one-cycle pulse granting port B.
- done, out, 1: one-cycle pulse when the granted transfer has finished.
- busy, out, 1: high in every state except IDLE.
- r2_up_t2_clr, out, 1: tank recirculation clear gate (write).
- r2_up_t2_in, out, 1: tank input gate (write).
- r2_up_t2_out, out, 1: tank output gate (read).
- digit_pos, out, 5: current digit position, 0..DIGITS-1.
- word_pos, out, 5: current word position, 0..WORDS-1.

## Operation
- Position counters:
  - digit_pos increments every edge and wraps from 17 to 0.
  - word_pos increments on each digit wrap and wraps from 31 to 0.
  - One full circulation is 576 cycles.
  - The counters run in every state.
- Arbitration happens in IDLE only:
  - Single request: that port is granted.
  - Both ports requesting: the port not granted last time wins (round-robin). After reset, A has priority.
- Grant cycle:
  - The winner's gnt pulses for one cycle.
  - wr, long and addr are latched in that same cycle.
  - The state moves to WAIT.
- Address rules:
  - When long = 1, addr[0] is forced to 0, so a long word occupies addresses addr and addr+1.
  - A long access at address 30 covers words 30–31 and does not wrap.
- States:
  - IDLE: waits for a request, then grants and goes to WAIT.
  - WAIT: leaves at the edge where digit_pos goes 17→0 and word_pos becomes the latched addr. At that same edge it enters XFER and asserts the gates.
  - XFER: holds the gates for 18 cycles (short) or 36 cycles (long), then goes to DONE.
  - DONE: pulses done for one cycle, then returns to IDLE.
- Gates (all registered):
  - Write: r2_up_t2_clr and r2_up_t2_in are both high, and r2_up_t2_out is low.
  - Read: only r2_up_t2_out is high.
  - A gate is high exactly in the cycles where word_pos equals the target word(s), for digit_pos 0..17.
  - At most one transfer is ever in flight, so gates for the two ports can never overlap.
- Requests during a transfer: a request arriving in WAIT, XFER or DONE is left pending. It is arbitrated on the first IDLE cycle.
- Reset:
  - Asynchronous; applies at any point, including mid-XFER.
  - State goes to IDLE, counters to 0, and all outputs low in the same instant.
  - Round-robin priority returns to A.
  - An aborted transfer never produces done.

## Timing
- Reset value of every output is 0, including digit_pos and word_pos.
- Request to grant:
  - req sampled high in IDLE at edge n gives gnt high for cycle n+1 (registered).
  - Back-to-back: done in cycle m, IDLE in m+1, next grant at m+2.
- Grant to first gate cycle is between 1 and 576 cycles. It depends on the tank position relative to addr.
- Boundary case: if the grant edge itself is the 17→0 edge into word addr, that occurrence is missed and the wait is a full 576 cycles.
- Gate widths are exactly 18 cycles (short) or 36 cycles (long), contiguous.
- done is high in the cycle immediately after the last gate cycle.
- busy rises with gnt and falls in the cycle after done.

## Test plan
- Reset release, no requests: digit_pos counts 0..17 and word_pos steps 0→31→0 every 576 cycles. All gates stay 0.
- Port A short read, addr 5, requested at word_pos 0 digit 0:
  - gnt_a pulses once.
  - r2_up_t2_out is high for exactly 18 cycles, covering word_pos = 5.
  - done pulses the next cycle; clr and in stay 0.
- Port B long write, addr 7:
  - Forced to 6.
  - clr and in are high for 36 cycles across words 6–7.
  - done follows, and out stays 0.
- req_a and req_b high together, both short reads at addr 3 and addr 20:
  - A is granted first.
  - B is granted 2 cycles after A's done.
  - The gate windows do not overlap.
- Grant edge coincides with entry into the target word: the gate is delayed exactly 576 cycles beyond that edge.
- r2_rst asserted mid-XFER of a write:
  - Gates, busy and counters drop to 0 immediately.
  - No done pulse.
  - After release, a pending req_b is granted ahead of A.

Source files
------------

// File: rtl/memory_r2_tank_ctrl.sv
// Sequencer and two-port round-robin arbiter for the EDSAC r2 upper mercury tank.
// Tracks the word at the tank output and gates clear/in/out for one granted word window.
module memory_r2_tank_ctrl #(
  parameter int unsigned DIGITS = 18,
  parameter int unsigned WORDS  = 32
) (
  input  logic       r2_clk,
  input  logic       r2_rst,
  input  logic       req_a,
  input  logic       req_a_wr,
  input  logic       req_a_long,
  input  logic [4:0] req_a_addr,
  input  logic       req_b,
  input  logic       req_b_wr,
  input  logic       req_b_long,
  input  logic [4:0] req_b_addr,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       done,
  output logic       busy,
  output logic       r2_up_t2_clr,
  output logic       r2_up_t2_in,
  output logic       r2_up_t2_out,
  output logic [4:0] digit_pos,
  output logic [4:0] word_pos
);

  localparam logic [4:0] DigLast  = 5'(DIGITS - 1);
  localparam logic [4:0] WordLast = 5'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StWait, StXfer, StDone} state_e;

  state_e     state_q, state_d;
  logic [4:0] digit_q, digit_d;
  logic [4:0] word_q, word_d;
  logic [4:0] addr_q, addr_d;
  logic       wr_q, wr_d;
  logic       lng_q, lng_d;
  logic       last_b_q, last_b_d;
  logic       gnt_a_q, gnt_a_d;
  logic       gnt_b_q, gnt_b_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       clr_q, clr_d;
  logic       in_q, in_d;
  logic       out_q, out_d;

  logic       digit_wrap;
  logic       pick_b;
  logic [4:0] word_next;
  logic [4:0] last_word;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    lng_d    = lng_q;
    last_b_d = last_b_q;
    gnt_a_d  = 1'b0;
    gnt_b_d  = 1'b0;
    done_d   = 1'b0;
    clr_d    = clr_q;
    in_d     = in_q;
    out_d    = out_q;
    pick_b   = 1'b0;

    digit_wrap = (digit_q == DigLast);
    digit_d    = digit_wrap ? 5'd0 : digit_q + 5'd1;
    word_next  = (word_q == WordLast) ? 5'd0 : word_q + 5'd1;
    word_d     = digit_wrap ? word_next : word_q;
    // A long access ends on the odd word of its pair.
    last_word  = lng_q ? (addr_q | 5'd1) : addr_q;

    unique case (state_q)
      StIdle: begin
        if (req_a || req_b) begin
          // B wins a tie only when A was the most recent grant.
          pick_b   = req_b && (!req_a || !last_b_q);
          gnt_a_d  = !pick_b;
          gnt_b_d  = pick_b;
          last_b_d = pick_b;
          wr_d     = pick_b ? req_b_wr   : req_a_wr;
          lng_d    = pick_b ? req_b_long : req_a_long;
          addr_d   = pick_b ? req_b_addr : req_a_addr;
          if (lng_d) addr_d[0] = 1'b0;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (digit_wrap && (word_next == addr_q)) begin
          state_d = StXfer;
          clr_d   = wr_q;
          in_d    = wr_q;
          out_d   = !wr_q;
        end
      end
      StXfer: begin
        if (digit_wrap && (word_q == last_word)) begin
          state_d = StDone;
          clr_d   = 1'b0;
          in_d    = 1'b0;
          out_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge r2_clk or posedge r2_rst) begin
    if (r2_rst) begin
      state_q  <= StIdle;
      digit_q  <= 5'd0;
      word_q   <= 5'd0;
      addr_q   <= 5'd0;
      wr_q     <= 1'b0;
      lng_q    <= 1'b0;
      last_b_q <= 1'b1;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      clr_q    <= 1'b0;
      in_q     <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      lng_q    <= lng_d;
      last_b_q <= last_b_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      clr_q    <= clr_d;
      in_q     <= in_d;
      out_q    <= out_d;
    end
  end

  assign gnt_a        = gnt_a_q;
  assign gnt_b        = gnt_b_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign r2_up_t2_clr = clr_q;
  assign r2_up_t2_in  = in_q;
  assign r2_up_t2_out = out_q;
  assign digit_pos    = digit_q;
  assign word_pos     = word_q;

endmodule

// File: tb/tb_memory_r2_tank_ctrl.sv
// Scoreboard bench for memory_r2_tank_ctrl: stimulus queues expected transfers,
// a negedge monitor derives gate windows from tank-position arithmetic.
module tb_memory_r2_tank_ctrl;

  localparam int Circ = 576;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_a_wr = 1'b0, req_a_long = 1'b0;
  logic [4:0] req_a_addr = '0;
  logic       req_b = 1'b0, req_b_wr = 1'b0, req_b_long = 1'b0;
  logic [4:0] req_b_addr = '0;
  logic       gnt_a, gnt_b, done, busy, g_clr, g_in, g_out;
  logic [4:0] digit_pos, word_pos;

  memory_r2_tank_ctrl #(.DIGITS(18), .WORDS(32)) dut (
    .r2_clk(clk), .r2_rst(rst),
    .req_a(req_a), .req_a_wr(req_a_wr), .req_a_long(req_a_long), .req_a_addr(req_a_addr),
    .req_b(req_b), .req_b_wr(req_b_wr), .req_b_long(req_b_long), .req_b_addr(req_b_addr),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done(done), .busy(busy),
    .r2_up_t2_clr(g_clr), .r2_up_t2_in(g_in), .r2_up_t2_out(g_out),
    .digit_pos(digit_pos), .word_pos(word_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit port;  // 1 = B
    bit wr;
    bit lng;
    int addr;
    int req_cyc;
  } txn_t;

  txn_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc;
  bit   last_b = 1'b1;

  // Cycles elapsed since reset release: the tank position reference.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard
  bit act_v = 1'b0;
  int g_cyc, s_cyc, w_len, last_done = -1000;
  bit t_wr;

  always @(negedge clk) begin
    if (rst) begin
      act_v     = 1'b0;
      last_done = -1000;
    end else begin
      automatic txn_t t;
      automatic int   eg, ae, d;
      automatic bit   eg_on, ed;
      chk("digit_pos", digit_pos, cyc % 18);
      chk("word_pos", word_pos, (cyc / 18) % 32);
      if (gnt_a || gnt_b) begin
        checks++;
        if (q.size() == 0 || act_v || (gnt_a && gnt_b)) begin
          errors++;
          $display("FAIL unexpected_gnt: got a=%0d b=%0d expected none", gnt_a, gnt_b);
        end else begin
          t  = q.pop_front();
          eg = (t.req_cyc + 1 > last_done + 2) ? t.req_cyc + 1 : last_done + 2;
          chk("gnt_port_b", gnt_b, t.port);
          chk("gnt_cycle", cyc, eg);
          ae = t.lng ? (t.addr & 30) : t.addr;
          d  = (((ae * 18 - cyc) % Circ) + Circ) % Circ;
          if (d == 0) d = Circ;
          act_v = 1'b1;
          g_cyc = cyc;
          s_cyc = cyc + d;
          w_len = t.lng ? 36 : 18;
          t_wr  = t.wr;
        end
      end
      eg_on = act_v && cyc >= s_cyc && cyc < s_cyc + w_len;
      ed    = act_v && cyc == s_cyc + w_len;
      chk("gate_clr", g_clr, eg_on && t_wr);
      chk("gate_in", g_in, eg_on && t_wr);
      chk("gate_out", g_out, eg_on && !t_wr);
      chk("done", done, ed);
      chk("busy", busy, act_v);
      if (ed) begin
        act_v     = 1'b0;
        last_done = cyc;
      end
      if (!act_v && !(gnt_a || gnt_b) && q.size() > 0) begin
        eg = (q[0].req_cyc + 1 > last_done + 2) ? q[0].req_cyc + 1 : last_done + 2;
        if (cyc > eg) begin
          checks++;
          errors++;
          $display("FAIL gnt_missing: got none by cycle %0d expected at %0d", cyc, eg);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic set_port(input bit p, input bit wr, input bit lng, input int addr);
    if (p) begin
      req_b = 1'b1; req_b_wr = wr; req_b_long = lng; req_b_addr = 5'(addr);
    end else begin
      req_a = 1'b1; req_a_wr = wr; req_a_long = lng; req_a_addr = 5'(addr);
    end
  endtask

  task automatic issue(input bit p, input bit wr, input bit lng, input int addr);
    set_port(p, wr, lng, addr);
    q.push_back('{port: p, wr: wr, lng: lng, addr: addr, req_cyc: cyc});
    last_b = p;
  endtask

  task automatic issue_both(input bit wa, input bit la, input int aa,
                            input bit wb, input bit lb, input int ab);
    set_port(1'b0, wa, la, aa);
    set_port(1'b1, wb, lb, ab);
    if (last_b) begin
      q.push_back('{port: 1'b0, wr: wa, lng: la, addr: aa, req_cyc: cyc});
      q.push_back('{port: 1'b1, wr: wb, lng: lb, addr: ab, req_cyc: cyc});
      last_b = 1'b1;
    end else begin
      q.push_back('{port: 1'b1, wr: wb, lng: lb, addr: ab, req_cyc: cyc});
      q.push_back('{port: 1'b0, wr: wa, lng: la, addr: aa, req_cyc: cyc});
      last_b = 1'b0;
    end
  endtask

  task automatic wait_clear();
    int n = 0;
    while ((req_a || req_b || busy) && n < 1500) begin
      @(negedge clk);
      if (gnt_a) req_a = 1'b0;
      if (gnt_b) req_b = 1'b0;
      n++;
    end
    chk("transfer_timeout", n >= 1500, 0);
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while ((cyc % Circ) != p && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk("pos_timeout", n >= 700, 0);
  endtask

  initial begin
    int n;
    #22 rst = 1'b0;
    // Free-running counters with no requests over more than one circulation
    repeat (600) @(negedge clk);

    // Port A short read of word 5, requested at word 0 digit 0
    wait_pos(0);
    issue(1'b0, 1'b0, 1'b0, 5);
    wait_clear();
    @(negedge clk);

    // Port B long write at odd address: pair 6-7
    issue(1'b1, 1'b1, 1'b1, 7);
    wait_clear();
    @(negedge clk);

    // Simultaneous short reads
    issue_both(1'b0, 1'b0, 3, 1'b0, 1'b0, 20);
    wait_clear();
    @(negedge clk);

    // Grant edge lands exactly on entry into word 9: full circulation wait
    wait_pos(9 * 18 - 1);
    issue(1'b0, 1'b0, 1'b0, 9);
    wait_clear();

    // Long access at the top of the tank
    issue(1'b1, 1'b0, 1'b1, 31);
    wait_clear();

    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk);
      if ($urandom_range(0, 3) == 0)
        issue_both($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 31),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 31));
      else
        issue($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 31));
      wait_clear();
    end

    // Reset in the middle of a write transfer, with port B pending
    issue(1'b0, 1'b1, 1'b1, 10);
    n = 0;
    while (!g_clr && n < 700) begin
      @(negedge clk);
      if (gnt_a) req_a = 1'b0;
      n++;
    end
    chk("xfer_reach_timeout", n >= 700, 0);
    repeat (5) @(negedge clk);
    req_b = 1'b1; req_b_wr = 1'b0; req_b_long = 1'b0; req_b_addr = 5'd4;
    #3 rst = 1'b1;
    #1;
    chk("rst_clr", g_clr, 0);
    chk("rst_in", g_in, 0);
    chk("rst_out", g_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_gnt", gnt_a | gnt_b, 0);
    chk("rst_digit", digit_pos, 0);
    chk("rst_word", word_pos, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    q.push_back('{port: 1'b1, wr: 1'b0, lng: 1'b0, addr: 4, req_cyc: cyc});
    last_b = 1'b1;
    wait_clear();
    repeat (40) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
